dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Round-robin arbiter that lets several CCSS processor cores share one single-port data memory. Each core issues a read or write request and holds it until a one-cycle acknowledge. The arbiter serialises the requests into memory cycles, respecting the memory's registered read latency. It sits between the cores' AR/DR/write-enable paths and the data memory instance.

## Interface

Parameters:
- NCORES, 4, number of requesting cores (≥2)
- AW, 16, address width
- DW, 16, data width
- RD_LAT, 1, memory read latency in cycles, from address edge to valid q (≥1)

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  reset, asynchronous assert, active-low (0 = reset)
- core_req  in  NCORES  per-core request; held high until that core's ack
- core_we  in  NCORES  per-core 1 = write, 0 = read
- core_addr  in  NCORES*AW  per-core address; core i at [i*AW +: AW]
- core_wdata  in  NCORES*DW  per-core write data; core i at [i*DW +: DW]
- core_ack  out  NCORES  one-hot, one-cycle completion pulse
- core_rdata  out  DW  read data; valid in the ack cycle, held until the next read capture
- mem_addr  out  AW  memory address
- mem_data  out  DW  memory write data
- mem_wren  out  1  memory write enable
- mem_q  in  DW  memory read data
- busy  out  1  high in every state except IDLE
- owner  out  clog2(NCORES)  index of the core currently being served

## Operation

- FSM states: IDLE, ISSUE, WAIT, ACK.
- **IDLE**
  - If any core_req bit is high, select the winner round-robin, searching from (last_grant+1) mod NCORES upward with wrap.
  - Latch the winner's index into owner, and its we, addr and wdata into internal registers. Go to ISSUE.
  - If no request is high, stay in IDLE.
- **ISSUE** (1 cycle)
  - mem_addr = latched addr, mem_data = latched wdata, mem_wren = latched we.
  - Write goes to ACK. Read loads the latency counter with RD_LAT and goes to WAIT.
- **WAIT**
  - mem_wren = 0; mem_addr holds.
  - Counter decrements each cycle. When it reaches 1, capture mem_q into core_rdata at that edge and go to ACK.
- **ACK** (1 cycle)
  - core_ack[owner] = 1; all other ack bits are 0.
  - last_grant = owner. Go to IDLE.
- **Request handshake**
  - A core must have req low in the cycle after its ack, unless it intends a new request.
  - A still-high req after ack is treated as a new request and arbitrated normally. Round-robin pointer movement gives the other cores priority.
- **Latched transactions**: once latched, a transaction completes even if its req drops mid-flight. The ack still pulses.
- **Register update scope**: core_rdata is updated only on read captures. Writes leave it unchanged.
- **Reset** (asynchronous, any state)
  - State goes to IDLE; last_grant = NCORES-1, so core 0 has first priority.
  - Output reset values: core_ack = 0, core_rdata = 0, mem_addr = 0, mem_data = 0, mem_wren = 0, busy = 0, owner = 0.
  - A transaction in flight is dropped with no ack. Its core must keep req high to be re-served after release.
- **Outputs**: all are registered or decoded from registered state only; no combinational path from core_req to any output.

## Timing

- Let cycle 0 be the IDLE cycle in which the request is sampled.
- **Write**
  - ISSUE in cycle 1, with mem_wren high for exactly that cycle.
  - Memory writes at the end of cycle 1.
  - ack in cycle 2. Total latency is 2 cycles.
- **Read**
  - ISSUE in cycle 1.
  - WAIT in cycles 2 … 1+RD_LAT; capture at the end of cycle 1+RD_LAT.
  - ack with valid core_rdata in cycle 2+RD_LAT. Total latency is 2+RD_LAT cycles (3 at the default).
- **Throughput**: at least one IDLE cycle between transactions. Back-to-back writes take 3 cycles each; reads take 3+RD_LAT cycles each.
- **Starvation bound**: a continuously held request is served within NCORES transactions.
- **Grant order**: simultaneous requests after reset are granted in order 0, 1, …, NCORES-1.

## Test plan

- **Reset**: hold rst=0 with random inputs → all outputs 0 and busy=0. Release with core_req=0 → stays in IDLE; mem_wren never high.
- **Single write**: core 1 writes addr 0x0010, data 0xBEEF → mem_wren=1 only in cycle 1 with mem_addr=0x0010 and mem_data=0xBEEF; core_ack=4'b0010 in cycle 2; core_rdata unchanged.
- **Read-back**: core 2 reads addr 0x0010 → mem_addr=0x0010 from cycle 1; core_ack=4'b0100 in cycle 3 with core_rdata=0xBEEF; core_rdata holds 0xBEEF afterwards.
- **All-core contention**: after reset, all 4 cores raise req together for writes to distinct addresses, each dropping req after its ack → acks in order core 0, 1, 2, 3, 3 cycles apart; memory contents match.
- **Fairness**: core 0 holds req permanently and core 2 requests repeatedly → grant sequence 0, 2, 0, 2, …; core 2 is never skipped.
- **Reset mid-read**: core 3 read in progress, rst=0 during WAIT → no ack, all outputs 0. After release, core 3 still requesting → re-served; ack in cycle 3 after the next IDLE sample, with correct data.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that serialises core read/write requests onto one
// single-port data memory with a registered read latency of RD_LAT cycles.
module dmem_arbiter #(
  parameter int NCORES = 4,
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter int RD_LAT = 1,
  localparam int IW    = (NCORES > 1) ? $clog2(NCORES) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCORES-1:0]    core_req,
  input  logic [NCORES-1:0]    core_we,
  input  logic [NCORES*AW-1:0] core_addr,
  input  logic [NCORES*DW-1:0] core_wdata,
  output logic [NCORES-1:0]    core_ack,
  output logic [DW-1:0]        core_rdata,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_data,
  output logic                 mem_wren,
  input  logic [DW-1:0]        mem_q,
  output logic                 busy,
  output logic [IW-1:0]        owner
);

  // state | meaning
  // IDLE  | pick round-robin winner, latch its request into the memory port
  // ISSUE | memory cycle: write strobes mem_wren, read starts latency count
  // WAIT  | read in flight; capture mem_q when the count reaches 1
  // ACK   | one-cycle ack to owner, advance round-robin pointer
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

  localparam int CW = $clog2(RD_LAT + 1);

  state_t             state;
  logic [IW-1:0]      last_grant;
  logic [IW-1:0]      win_idx;
  logic               win_found;
  logic               win_we;
  logic [AW-1:0]      win_addr;
  logic [DW-1:0]      win_data;
  logic               lat_we;
  logic [CW-1:0]      lat_cnt;
  logic [NCORES-1:0]  ack_onehot;
  int                 idx;

  // Search starts just past the last served core so a held request cannot
  // lock out the others.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_we    = 1'b0;
    win_addr  = '0;
    win_data  = '0;
    idx       = 0;
    for (int k = 1; k <= NCORES; k++) begin
      idx = (int'(last_grant) + k) % NCORES;
      if (!win_found && core_req[idx]) begin
        win_found = 1'b1;
        win_idx   = IW'(idx);
        win_we    = core_we[idx];
        win_addr  = core_addr[idx*AW +: AW];
        win_data  = core_wdata[idx*DW +: DW];
      end
    end
  end

  assign ack_onehot = NCORES'(1) << owner;
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      last_grant <= IW'(NCORES - 1);
      owner      <= '0;
      lat_we     <= 1'b0;
      lat_cnt    <= '0;
      core_ack   <= '0;
      core_rdata <= '0;
      mem_addr   <= '0;
      mem_data   <= '0;
      mem_wren   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_found) begin
            owner    <= win_idx;
            lat_we   <= win_we;
            mem_addr <= win_addr;
            mem_data <= win_data;
            mem_wren <= win_we;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mem_wren <= 1'b0;
          if (lat_we) begin
            core_ack <= ack_onehot;
            state    <= S_ACK;
          end else begin
            lat_cnt <= CW'(RD_LAT);
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (lat_cnt == CW'(1)) begin
            core_rdata <= mem_q;
            core_ack   <= ack_onehot;
            state      <= S_ACK;
          end else begin
            lat_cnt <= lat_cnt - CW'(1);
          end
        end
        S_ACK: begin
          core_ack   <= '0;
          last_grant <= owner;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level round-robin model predicts every
// cycle's ack/busy/memory-port values; directed scenarios plus random traffic.
module tb_dmem_arbiter;
  localparam int NC = 4, AW = 16, DW = 16, RD_LAT = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NC-1:0]     core_req, core_we, core_ack;
  logic [NC*AW-1:0]  core_addr;
  logic [NC*DW-1:0]  core_wdata;
  logic [DW-1:0]     core_rdata, mem_data, mem_q;
  logic [AW-1:0]     mem_addr;
  logic              mem_wren, busy;
  logic [1:0]        owner;

  dmem_arbiter #(.NCORES(NC), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .core_req(core_req), .core_we(core_we),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_ack(core_ack),
    .core_rdata(core_rdata), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_wren(mem_wren), .mem_q(mem_q), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  // synchronous RAM with RD_LAT-cycle registered read
  logic [DW-1:0] ram [0:255] = '{default: '0};
  logic [DW-1:0] q_pipe [RD_LAT];
  always @(posedge clk) begin
    if (mem_wren) ram[mem_addr[7:0]] <= mem_data;
    q_pipe[0] <= ram[mem_addr[7:0]];
    for (int k = 1; k < RD_LAT; k++) q_pipe[k] <= q_pipe[k-1];
  end
  assign mem_q = q_pipe[RD_LAT-1];

  int n_cmp = 0, n_mis = 0, cyc = 0;

  // core agents: mode 0 one-shot, 1 random, 2 persistent
  int            mode [NC];
  logic          a_req [NC], a_we [NC], ack_prev [NC];
  logic [AW-1:0] a_addr [NC];
  logic [DW-1:0] a_wd [NC];

  // reference model
  bit            m_busy;
  int            m_issue, m_ack, m_own, m_last;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd, m_rd, m_rd_next;
  logic [DW-1:0] mmem [0:255] = '{default: '0};

  int dut_log[$], dut_ack_cyc[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NC; i++) begin
      core_req[i]              = a_req[i];
      core_we[i]               = a_we[i];
      core_addr[i*AW +: AW]    = a_addr[i];
      core_wdata[i*DW +: DW]   = a_wd[i];
    end
  endtask

  task automatic new_req(input int i);
    a_req[i]  = 1'b1;
    a_we[i]   = 1'($urandom_range(0, 1));
    a_addr[i] = AW'($urandom_range(0, 15));
    a_wd[i]   = DW'($urandom);
  endtask

  task automatic arbitrate();
    bit found;
    int i;
    found = 1'b0;
    if (!m_busy) begin
      for (int k = 1; k <= NC; k++) begin
        i = (m_last + k) % NC;
        if (!found && a_req[i]) begin
          found   = 1'b1;
          m_busy  = 1'b1;
          m_own   = i;
          m_last  = i;
          m_we    = a_we[i];
          m_addr  = a_addr[i];
          m_wd    = a_wd[i];
          m_issue = cyc + 1;
          m_ack   = cyc + (m_we ? 2 : 2 + RD_LAT);
          if (m_we) mmem[m_addr[7:0]] = m_wd;
          else      m_rd_next = mmem[m_addr[7:0]];
        end
      end
    end
  endtask

  task automatic agents(input logic [NC-1:0] ack_now);
    for (int i = 0; i < NC; i++) begin
      if (ack_prev[i]) begin
        if (mode[i] == 2 || (mode[i] == 1 && $urandom_range(0, 3) == 0)) new_req(i);
        else a_req[i] = 1'b0;
      end else if (!a_req[i] && mode[i] == 1 && $urandom_range(0, 2) == 0) begin
        new_req(i);
      end
      ack_prev[i] = ack_now[i];
    end
  endtask

  task automatic step();
    logic [NC-1:0] exp_ack;
    @(posedge clk);
    #1;
    cyc++;
    exp_ack = '0;
    if (m_busy && cyc == m_ack) begin
      exp_ack[m_own] = 1'b1;
      if (!m_we) m_rd = m_rd_next;
    end
    check("ack", core_ack, exp_ack);
    check("busy", busy, m_busy);
    check("wren", mem_wren, m_busy && m_we && cyc == m_issue);
    check("rdata", core_rdata, m_rd);
    if (m_busy) begin
      check("owner", owner, m_own);
      check("addr", mem_addr, m_addr);
      if (m_we && cyc == m_issue) check("wdata", mem_data, m_wd);
    end
    for (int i = 0; i < NC; i++)
      if (core_ack[i]) begin
        dut_log.push_back(i);
        dut_ack_cyc.push_back(cyc);
      end
    agents(exp_ack);
    drive();
    arbitrate();
    if (m_busy && cyc == m_ack) m_busy = 1'b0;
  endtask

  task automatic post(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    a_req[i] = 1'b1; a_we[i] = we; a_addr[i] = a; a_wd[i] = d;
    drive();
    arbitrate();
  endtask

  task automatic do_reset(input bit rand_in, input int n);
    rst = 1'b0;
    #1;
    m_busy = 1'b0; m_last = NC - 1; m_rd = '0;
    for (int i = 0; i < NC; i++) ack_prev[i] = 1'b0;
    check("rst_ack", core_ack, 0);
    check("rst_rdata", core_rdata, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_data", mem_data, 0);
    check("rst_wren", mem_wren, 0);
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 0);
    repeat (n) begin
      if (rand_in) begin
        core_req = NC'($urandom); core_we = NC'($urandom);
        core_addr = {$urandom, $urandom}; core_wdata = {$urandom, $urandom};
      end
      @(posedge clk);
      #1;
      cyc++;
      check("rst_hold_ack", core_ack, 0);
      check("rst_hold_busy", busy, 0);
      check("rst_hold_wren", mem_wren, 0);
    end
  endtask

  task automatic release_rst();
    drive();
    rst = 1'b1;
    arbitrate();
  endtask

  logic [DW-1:0] cdat [NC];
  int t0;

  initial begin
    for (int i = 0; i < NC; i++) begin
      mode[i] = 0; a_req[i] = 1'b0; a_we[i] = 1'b0; a_addr[i] = '0; a_wd[i] = '0; ack_prev[i] = 1'b0;
    end
    m_busy = 1'b0; m_last = NC - 1; m_rd = '0; m_rd_next = '0;
    drive();

    // reset with random inputs, then idle release
    do_reset(1'b1, 4);
    release_rst();
    repeat (6) step();

    // single write
    t0 = cyc;
    dut_log.delete(); dut_ack_cyc.delete();
    post(1, 1'b1, 16'h0010, 16'hBEEF);
    repeat (6) step();
    check("wr_n", dut_log.size(), 1);
    if (dut_log.size() > 0) begin
      check("wr_who", dut_log[0], 1);
      check("wr_lat", dut_ack_cyc[0] - t0, 2);
    end
    check("wr_rdata", core_rdata, 0);

    // read-back
    t0 = cyc;
    dut_log.delete(); dut_ack_cyc.delete();
    post(2, 1'b0, 16'h0010, 16'h0000);
    repeat (8) step();
    check("rd_n", dut_log.size(), 1);
    if (dut_log.size() > 0) begin
      check("rd_who", dut_log[0], 2);
      check("rd_lat", dut_ack_cyc[0] - t0, 2 + RD_LAT);
    end
    check("rd_data", core_rdata, 16'hBEEF);

    // all-core contention after reset
    do_reset(1'b0, 2);
    for (int i = 0; i < NC; i++) begin
      cdat[i] = DW'($urandom);
      a_req[i] = 1'b1; a_we[i] = 1'b1; a_addr[i] = AW'(16'h20 + i); a_wd[i] = cdat[i];
    end
    dut_log.delete(); dut_ack_cyc.delete();
    release_rst();
    repeat (16) step();
    check("cont_n", dut_log.size(), NC);
    for (int k = 0; k < NC && k < dut_log.size(); k++) begin
      check("cont_order", dut_log[k], k);
      if (k > 0) check("cont_gap", dut_ack_cyc[k] - dut_ack_cyc[k-1], 3);
    end
    for (int i = 0; i < NC; i++) check("cont_mem", ram[8'h20 + i], cdat[i]);

    // fairness: cores 0 and 2 both keep requesting
    dut_log.delete(); dut_ack_cyc.delete();
    mode[0] = 2; mode[2] = 2;
    post(0, 1'b1, 16'h0005, 16'h1234);
    post(2, 1'b1, 16'h0006, 16'h5678);
    repeat (30) step();
    mode[0] = 0; mode[2] = 0;
    repeat (16) step();
    check("fair_n", dut_log.size() >= 8, 1);
    for (int k = 0; k < 8 && k < dut_log.size(); k++)
      check("fair_order", dut_log[k], (k % 2) ? 2 : 0);

    // reset during a read's WAIT cycle
    t0 = cyc;
    dut_log.delete(); dut_ack_cyc.delete();
    post(3, 1'b0, 16'h0020, 16'h0000);
    step();
    step();
    check("mid_pre_n", dut_log.size(), 0);
    do_reset(1'b0, 2);
    t0 = cyc;
    release_rst();
    repeat (8) step();
    check("mid_n", dut_log.size(), 1);
    if (dut_log.size() > 0) begin
      check("mid_who", dut_log[0], 3);
      check("mid_lat", dut_ack_cyc[0] - t0, 2 + RD_LAT);
    end
    check("mid_data", core_rdata, cdat[0]);

    // random traffic from all cores
    for (int i = 0; i < NC; i++) mode[i] = 1;
    repeat (3000) step();
    for (int i = 0; i < NC; i++) mode[i] = 0;
    repeat (40) step();
    for (int a = 0; a < 16; a++) check("rand_mem", ram[a], mmem[a]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
